// File: rtl/mdu_pkg.sv
// Shared MDU definitions: op codes, default latencies and the launch-result record.
// The decoder and hazard unit import this same package.
package mdu_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MTHI  = 4'd5,
        MDU_MTLO  = 4'd6,
        MDU_MFHI  = 4'd7,
        MDU_MFLO  = 4'd8
    } mdu_op_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // Result captured at launch; skip marks a divide by zero (HI/LO left untouched).
    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        skip;
    } mdu_res_t;

endpackage

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit: result is computed at launch into shadow
// registers and committed to HI/LO when the busy counter expires.
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Start,
    input  logic [3:0]  MDUOp,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDUOut
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    mdu_op_e         op;
    logic [CW-1:0]   cnt;
    mdu_res_t        shd;
    mdu_res_t        res;
    logic            launch;
    logic            is_div;
    logic signed [31:0] sa, sb;
    logic [63:0]     sprod, uprod;

    assign op     = mdu_op_e'(MDUOp);
    assign Busy   = (cnt != '0);
    assign is_div = (op == MDU_DIV) || (op == MDU_DIVU);
    assign launch = Start && !Busy &&
                    (op == MDU_MULT || op == MDU_MULTU || is_div);

    assign sa    = SrcA;
    assign sb    = SrcB;
    assign sprod = 64'(sa) * 64'(sb);
    assign uprod = {32'h0, SrcA} * {32'h0, SrcB};

    always_comb begin
        res = '0;
        case (op)
            MDU_MULT:  {res.hi, res.lo} = sprod;
            MDU_MULTU: {res.hi, res.lo} = uprod;
            MDU_DIV: begin
                if (SrcB == 32'h0) begin
                    res.skip = 1'b1;
                end else if (SrcA == 32'h8000_0000 && SrcB == 32'hFFFF_FFFF) begin
                    // Quotient +2^31 wraps; remainder is exactly zero.
                    res.lo = 32'h8000_0000;
                    res.hi = 32'h0;
                end else begin
                    res.lo = sa / sb;
                    res.hi = sa % sb;
                end
            end
            MDU_DIVU: begin
                if (SrcB == 32'h0) begin
                    res.skip = 1'b1;
                end else begin
                    res.lo = SrcA / SrcB;
                    res.hi = SrcA % SrcB;
                end
            end
            default: res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            shd <= '0;
            HI  <= 32'h0;
            LO  <= 32'h0;
        end else if (launch) begin
            shd <= res;
            cnt <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end else if (Busy) begin
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1) && !shd.skip) begin
                HI <= shd.hi;
                LO <= shd.lo;
            end
        end else begin
            if (op == MDU_MTHI) HI <= SrcA;
            if (op == MDU_MTLO) LO <= SrcA;
        end
    end

    always_comb begin
        MDUOut = 32'h0;
        case (op)
            MDU_MFHI: MDUOut = HI;
            MDU_MFLO: MDUOut = LO;
            default:  MDUOut = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_mdu.sv
// Randomized self-checking bench for mdu against an arithmetic reference model.
module tb_mdu;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Start = 1'b0;
    logic [3:0]  MDUOp = 4'd0;
    logic [31:0] SrcA = 32'h0;
    logic [31:0] SrcB = 32'h0;
    logic        Busy;
    logic [31:0] HI, LO, MDUOut;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] m_hi = 32'h0;
    logic [31:0] m_lo = 32'h0;

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .rst_n(rst_n), .Start(Start), .MDUOp(MDUOp),
        .SrcA(SrcA), .SrcB(SrcB), .Busy(Busy), .HI(HI), .LO(LO), .MDUOut(MDUOut)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Reference: the architectural effect of a completed mult/div.
    task automatic ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint x, y, q, r;
        logic [63:0] p;
        case (op)
            4'd1: begin
                x = longint'($signed(a)); y = longint'($signed(b));
                p = 64'(x * y); m_hi = p[63:32]; m_lo = p[31:0];
            end
            4'd2: begin
                x = longint'({32'h0, a}); y = longint'({32'h0, b});
                p = 64'(x * y); m_hi = p[63:32]; m_lo = p[31:0];
            end
            4'd3, 4'd4: begin
                if (b != 0) begin
                    if (op == 4'd3) begin
                        x = longint'($signed(a)); y = longint'($signed(b));
                    end else begin
                        x = longint'({32'h0, a}); y = longint'({32'h0, b});
                    end
                    q = x / y; r = x % y;
                    m_lo = q[31:0]; m_hi = r[31:0];
                end
            end
            default: ;
        endcase
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit inject);
        int n;
        int exp_n;
        logic [31:0] old_hi, old_lo;
        old_hi = m_hi; old_lo = m_lo;
        exp_n = (op >= 4'd3) ? 10 : 5;
        @(negedge clk);
        chk("idle_busy", {31'h0, Busy}, 32'h0);
        MDUOp = op; SrcA = a; SrcB = b; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0; MDUOp = 4'd0; SrcA = $urandom; SrcB = $urandom;
        n = 0;
        while (Busy && n < 40) begin
            chk("busy_hi_hold", HI, old_hi);
            chk("busy_lo_hold", LO, old_lo);
            if (inject && n == 2) begin Start = 1'b1; MDUOp = 4'd2; end
            if (inject && n == 3) begin Start = 1'b0; MDUOp = 4'd5; SrcA = 32'hDEAD_BEEF; end
            if (inject && n == 4) MDUOp = 4'd0;
            n++;
            @(negedge clk);
        end
        chk("busy_cycles", 32'(n), 32'(exp_n));
        ref_op(op, a, b);
        chk("res_hi", HI, m_hi);
        chk("res_lo", LO, m_lo);
        @(negedge clk);
        chk("no_relaunch", {31'h0, Busy}, 32'h0);
    endtask

    task automatic mt(input logic [3:0] op, input logic [31:0] v);
        @(negedge clk);
        MDUOp = op; SrcA = v;
        @(negedge clk);
        MDUOp = 4'd0;
        if (op == 4'd5) m_hi = v; else m_lo = v;
        chk("mt_hi", HI, m_hi);
        chk("mt_lo", LO, m_lo);
    endtask

    task automatic mf();
        @(negedge clk);
        MDUOp = 4'd7; #1 chk("mfhi", MDUOut, m_hi);
        MDUOp = 4'd8; #1 chk("mflo", MDUOut, m_lo);
        MDUOp = 4'd0; #1 chk("mfnone", MDUOut, 32'h0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #12;
        chk("rst_busy", {31'h0, Busy}, 32'h0);
        chk("rst_hi", HI, 32'h0);
        chk("rst_lo", LO, 32'h0);
        rst_n = 1'b1;

        run_op(4'd1, 32'hFFFF_FFFE, 32'h3, 1'b0);
        chk("mult_hi_lit", HI, 32'hFFFF_FFFF);
        chk("mult_lo_lit", LO, 32'hFFFF_FFFA);
        run_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        chk("multu_hi_lit", HI, 32'hFFFF_FFFE);
        chk("multu_lo_lit", LO, 32'h0000_0001);
        run_op(4'd3, 32'hFFFF_FFF9, 32'h2, 1'b0);
        chk("div_lo_lit", LO, 32'hFFFF_FFFD);
        chk("div_hi_lit", HI, 32'hFFFF_FFFF);
        mt(4'd5, 32'h11);
        mt(4'd6, 32'h22);
        run_op(4'd4, 32'h7, 32'h0, 1'b0);
        chk("div0_hi_lit", HI, 32'h11);
        chk("div0_lo_lit", LO, 32'h22);
        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("ovf_lo_lit", LO, 32'h8000_0000);
        chk("ovf_hi_lit", HI, 32'h0);
        run_op(4'd3, 32'd100, 32'hFFFF_FFF9, 1'b1);
        mt(4'd5, 32'h1234_5678);
        mf();

        // Asynchronous reset during busy cycle 4 of a mult.
        @(negedge clk);
        MDUOp = 4'd1; SrcA = 32'h1234; SrcB = 32'h5678; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0; MDUOp = 4'd0;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", {31'h0, Busy}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'h0, Busy}, 32'h0);
        chk("arst_hi", HI, 32'h0);
        chk("arst_lo", LO, 32'h0);
        m_hi = 32'h0; m_lo = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            chk("post_rst_busy", {31'h0, Busy}, 32'h0);
            chk("post_rst_hi", HI, 32'h0);
            chk("post_rst_lo", LO, 32'h0);
        end
        run_op(4'd1, 32'h7, 32'h6, 1'b0);

        for (int i = 0; i < 60; i++) begin
            logic [3:0] op;
            op = 4'($urandom_range(1, 8));
            case (op)
                4'd5, 4'd6: mt(op, $urandom);
                4'd7, 4'd8: mf();
                default:    run_op(op, pick(), pick(), ($urandom_range(0, 3) == 0) && op >= 4'd3);
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
